// File: rtl/da_shift_accumulator_if.sv
// Handshake/bus bundle between the DA accumulator, its subfilter and the result consumer.
// master = the side that drives start/p_in/y_ready, slave = the accumulator.
interface da_shift_accumulator_if #(
    parameter int word_width = 16
);
    logic                  start;
    logic                  sub_x_we;
    logic                  sub_en;
    logic                  sub_Ts;
    logic [word_width-1:0] p_in;
    logic                  busy;
    logic                  y_valid;
    logic                  y_ready;
    logic [word_width-1:0] y_out;

    modport master (
        output start, p_in, y_ready,
        input  sub_x_we, sub_en, sub_Ts, busy, y_valid, y_out
    );

    modport slave (
        input  start, p_in, y_ready,
        output sub_x_we, sub_en, sub_Ts, busy, y_valid, y_out
    );
endinterface

// File: rtl/da_shift_accumulator.sv
// Sequencer + shift-and-add accumulator for a bit-serial distributed-arithmetic FIR subfilter.
// Weights each per-bit ROM partial sum by 2^k (sign bit negative), then scales and saturates.
module da_shift_accumulator #(
    parameter int word_width = 16,
    parameter int ROM_LAT    = 1,
    parameter int OUT_SHIFT  = 15
) (
    input logic                  clk,
    input logic                  rst,
    da_shift_accumulator_if.slave bus
);
    localparam int ACC_W = 2 * word_width + 1;
    localparam int JW    = $clog2(word_width);
    localparam logic [JW-1:0] LAST = JW'(word_width - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-word_width+1){1'b0}}, {(word_width-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [JW-1:0]           j_q, j_d;
    logic                    tok_vld_q, tok_vld_d;
    logic [JW-1:0]           tok_k_q, tok_k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    x_we_q, x_we_d, en_q, en_d, ts_q, ts_d;
    logic                    busy_q, busy_d, yv_q, yv_d;
    logic [word_width-1:0]   y_q, y_d;

    logic                    em_vld;
    logic [JW-1:0]           em_k, j_nxt;
    logic signed [ACC_W-1:0] term, shifted;
    logic                    enter_hold;

    // With ROM_LAT=0 the partial sum belongs to the bit being addressed this very cycle.
    assign em_vld = (ROM_LAT == 0) ? (state_q == RUN) : tok_vld_q;
    assign em_k   = (ROM_LAT == 0) ? j_q : tok_k_q;
    assign j_nxt  = j_q + JW'(1);
    assign term   = $signed({{(ACC_W-word_width){bus.p_in[word_width-1]}}, bus.p_in}) <<< em_k;

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        tok_vld_d  = (state_q == RUN);
        tok_k_d    = j_q;
        acc_d      = acc_q;
        x_we_d     = 1'b0;
        en_d       = 1'b0;
        ts_d       = 1'b0;
        busy_d     = busy_q;
        yv_d       = yv_q;
        y_d        = y_q;
        enter_hold = 1'b0;
        shifted    = '0;

        if (em_vld) acc_d = (em_k == LAST) ? acc_q - term : acc_q + term;

        case (state_q)
            IDLE: if (bus.start) begin
                state_d = LOAD;
                acc_d   = '0;
                busy_d  = 1'b1;
                x_we_d  = 1'b1;
                en_d    = 1'b1;
            end
            LOAD: begin
                state_d = RUN;
                j_d     = '0;
                en_d    = 1'b1;
                ts_d    = (LAST == '0);
            end
            RUN: if (j_q == LAST) begin
                state_d    = (ROM_LAT == 0) ? HOLD : DRAIN;
                enter_hold = (ROM_LAT == 0);
            end else begin
                j_d  = j_nxt;
                en_d = 1'b1;
                ts_d = (j_nxt == LAST);
            end
            DRAIN: begin
                state_d    = HOLD;
                enter_hold = 1'b1;
            end
            HOLD: if (bus.y_ready) begin
                state_d = IDLE;
                yv_d    = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Final accumulation and output capture happen on the same edge.
        if (enter_hold) begin
            shifted = acc_d >>> OUT_SHIFT;
            yv_d    = 1'b1;
            if (shifted > SAT_MAX)      y_d = SAT_MAX[word_width-1:0];
            else if (shifted < SAT_MIN) y_d = SAT_MIN[word_width-1:0];
            else                        y_d = shifted[word_width-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= '0;
            tok_vld_q <= 1'b0;
            tok_k_q   <= '0;
            acc_q     <= '0;
            x_we_q    <= 1'b0;
            en_q      <= 1'b0;
            ts_q      <= 1'b0;
            busy_q    <= 1'b0;
            yv_q      <= 1'b0;
            y_q       <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            tok_vld_q <= tok_vld_d;
            tok_k_q   <= tok_k_d;
            acc_q     <= acc_d;
            x_we_q    <= x_we_d;
            en_q      <= en_d;
            ts_q      <= ts_d;
            busy_q    <= busy_d;
            yv_q      <= yv_d;
            y_q       <= y_d;
        end
    end

    assign bus.sub_x_we = x_we_q;
    assign bus.sub_en   = en_q;
    assign bus.sub_Ts   = ts_q;
    assign bus.busy     = busy_q;
    assign bus.y_valid  = yv_q;
    assign bus.y_out    = y_q;
endmodule

// File: tb/tb_da_shift_accumulator.sv
// Drives three accumulators (base, OUT_SHIFT=7, ROM_LAT=0) in lockstep from a modelled subfilter
// and compares results against a weighted-sum reference computed from the partial-sum table.
module tb_da_shift_accumulator;
    logic clk = 1'b0;
    logic rst, start, y_ready;
    always #5 clk = ~clk;

    da_shift_accumulator_if #(.word_width(8)) if0 ();
    da_shift_accumulator_if #(.word_width(8)) if1 ();
    da_shift_accumulator_if #(.word_width(8)) if2 ();

    da_shift_accumulator #(.word_width(8), .ROM_LAT(1), .OUT_SHIFT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    da_shift_accumulator #(.word_width(8), .ROM_LAT(1), .OUT_SHIFT(7)) u1 (.clk(clk), .rst(rst), .bus(if1));
    da_shift_accumulator #(.word_width(8), .ROM_LAT(0), .OUT_SHIFT(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
    assign if0.y_ready = y_ready; assign if1.y_ready = y_ready; assign if2.y_ready = y_ready;

    // Subfilter model: tab[k] is the ROM partial sum for address bit k; junk when no bit is addressed.
    logic [7:0] tab [8];
    logic [2:0] c0, c1, c2;
    logic [7:0] p0, p1, junk;
    always @(posedge clk) begin
        junk <= 8'($urandom);
        if (if0.sub_x_we) c0 <= '0; else if (if0.sub_en) c0 <= c0 + 3'd1;
        if (if1.sub_x_we) c1 <= '0; else if (if1.sub_en) c1 <= c1 + 3'd1;
        if (if2.sub_x_we) c2 <= '0; else if (if2.sub_en) c2 <= c2 + 3'd1;
        p0 <= (if0.sub_en && !if0.sub_x_we) ? tab[c0] : 8'($urandom);
        p1 <= (if1.sub_en && !if1.sub_x_we) ? tab[c1] : 8'($urandom);
    end
    assign if0.p_in = p0;
    assign if1.p_in = p1;
    assign if2.p_in = (if2.sub_en && !if2.sub_x_we) ? tab[c2] : junk;

    int npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Two's-complement value of the sample bits: sum of p_k * 2^k, with the sign bit weighted -2^7.
    function automatic logic [7:0] ref_y(input int sh);
        int acc = 0;
        int v;
        for (int k = 0; k < 8; k++) begin
            v = int'($signed(tab[k]));
            acc += (k == 7) ? -(v * 128) : v * (2 ** k);
        end
        acc = acc >>> sh;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return 8'(acc);
    endfunction

    task automatic set_tab(input int a0, a1, a2, a3, a4, a5, a6, a7);
        tab[0] = 8'(a0); tab[1] = 8'(a1); tab[2] = 8'(a2); tab[3] = 8'(a3);
        tab[4] = 8'(a4); tab[5] = 8'(a5); tab[6] = 8'(a6); tab[7] = 8'(a7);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {if0.busy, if0.y_valid, if0.sub_x_we, if0.sub_en, if0.sub_Ts}, 0);
        chk({tag, "_y"}, if0.y_out, 0);
        chk({tag, "_rl0"}, {if2.busy, if2.y_valid, if2.sub_en, if2.y_out}, 0);
    endtask

    task automatic run_txn(input bit early);
        int lat0 = -1, lat1 = -1, lat2 = -1;
        logic [7:0] yo0 = '0, yo1 = '0, yo2 = '0;
        int we_cnt = 0, we_cyc = 0, en_cnt = 0, ts_cnt = 0, ts_cyc = 0, v_cnt = 0;
        y_ready = early;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (if0.sub_x_we) begin we_cnt++; we_cyc = c; end
            if (if0.sub_en) en_cnt++;
            if (if0.sub_Ts) begin ts_cnt++; ts_cyc = c; end
            if (if0.y_valid) v_cnt++;
            if (if0.y_valid && lat0 < 0) begin lat0 = c; yo0 = if0.y_out; end
            if (if1.y_valid && lat1 < 0) begin lat1 = c; yo1 = if1.y_out; end
            if (if2.y_valid && lat2 < 0) begin lat2 = c; yo2 = if2.y_out; end
            if (lat0 >= 0 && lat1 >= 0 && lat2 >= 0 &&
                (!early || !(if0.busy || if1.busy || if2.busy))) break;
        end
        chk("lat_rl1", lat0, 11);
        chk("lat_sh7", lat1, 11);
        chk("lat_rl0", lat2, 10);
        chk("y_base", yo0, ref_y(0));
        chk("y_sh7", yo1, ref_y(7));
        chk("y_rl0", yo2, ref_y(0));
        chk("xwe_pulse", {we_cnt, we_cyc}, {32'd1, 32'd1});
        chk("en_cycles", en_cnt, 9);
        chk("ts_pos", {ts_cnt, ts_cyc}, {32'd1, 32'd9});
        chk("valid_len", v_cnt, 1);
        if (!early) begin
            y_ready = 1'b1;
            @(negedge clk);
            chk("handoff", {if0.busy, if0.y_valid, if2.busy, if2.y_valid}, 0);
        end
        chk("y_retained", if0.y_out, ref_y(0));
        y_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; y_ready = 1'b0;
        set_tab(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;

        // Directed value cases: -1, plain LSB, negative clamp, positive clamp / scaled.
        set_tab(1, 1, 1, 1, 1, 1, 1, 1);           run_txn(1'b0);
        set_tab(5, 0, 0, 0, 0, 0, 0, 0);           run_txn(1'b1);
        set_tab(0, 0, 0, 0, 0, 0, 0, 3);           run_txn(1'b0);
        set_tab(127, 127, 127, 127, 127, 127, 127, 0); run_txn(1'b0);
        chk("pos_clamp_lit", if0.y_out, 8'h7F);
        chk("sh7_lit", if1.y_out, 8'h7E);

        // Back-pressure: 5 stalled HOLD cycles with an ignored start pulse in the middle.
        set_tab(-3, 2, -7, 100, 0, -1, 4, 9);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 2; c <= 20 && !if0.y_valid; c++) @(negedge clk);
        chk("hold_reach", if0.y_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            @(negedge clk);
            chk("hold_stable", {if0.y_valid, if0.busy, if0.sub_x_we, if0.y_out}, {3'b110, ref_y(0)});
        end
        y_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("hold_exit", {if0.busy, if0.y_valid}, 0);
        start = 1'b0; y_ready = 1'b0;
        @(negedge clk);
        chk("start_at_handoff_ignored", {if0.busy, if0.sub_x_we, if0.sub_en}, 0);

        // Reset mid-RUN (bit 3 addressed), then a clean rerun of the all-ones case.
        set_tab(1, 1, 1, 1, 1, 1, 1, 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_run", {if0.sub_en, if0.sub_Ts, if0.busy}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_rst");
        rst = 1'b0;
        run_txn(1'b0);

        // Randomized partial sums, random same-cycle vs late handshake.
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 8; k++) tab[k] = 8'($urandom);
            run_txn(1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
